pcs_tx_147: RTL

PCS_TX_147 -- requirements
Module: pcs_tx_147

---
 rtl/pcs_tx_147_if.sv | 25 ++
 rtl/pcs_tx_147.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_147_if.sv
// Transmit-side bus of the PCS transmitter: symbol strobe, MII inputs,
// command input and the registered symbol/status outputs.
interface pcs_tx_147_if;
    logic       tx_std;
    logic       link_control;
    logic       TX_EN;
    logic       TX_ER;
    logic [3:0] TXD;
    logic [1:0] tx_cmd;
    logic [4:0] tx_sym;
    logic       transmitting;
    logic [2:0] tx_state;

    // Source of the MII/command inputs, consumer of the symbol stream
    modport master (
        output tx_std, link_control, TX_EN, TX_ER, TXD, tx_cmd,
        input  tx_sym, transmitting, tx_state
    );

    // The PCS transmitter itself
    modport slave (
        input  tx_std, link_control, TX_EN, TX_ER, TXD, tx_cmd,
        output tx_sym, transmitting, tx_state
    );
endinterface

// File: rtl/pcs_tx_147.sv
// PCS transmitter: turns MII frames and idle-time commands into a stream of
// 5-bit line symbols, one symbol per tx_std strobe.
module pcs_tx_147 #(
    parameter int N_SYNC = 2
) (
    input  logic         clk,
    input  logic         pcs_reset,
    pcs_tx_147_if.slave  bus
);
    localparam logic [4:0] SYM_SILENCE = 5'b11111;
    localparam logic [4:0] SYM_SYNC    = 5'b11000;
    localparam logic [4:0] SYM_SSD     = 5'b10001;
    localparam logic [4:0] SYM_ESD     = 5'b01101;
    localparam logic [4:0] SYM_ESDOK   = 5'b00111;
    localparam logic [4:0] SYM_ESDERR  = 5'b00100;
    localparam logic [4:0] SYM_BEACON  = 5'b01000;
    localparam logic [4:0] SYM_HB      = 5'b00110;
    localparam logic [4:0] SYM_ERR     = 5'b00100;

    localparam logic [1:0] CMD_NONE   = 2'd0;
    localparam logic [1:0] CMD_COMMIT = 2'd1;
    localparam logic [1:0] CMD_BEACON = 2'd2;

    // precnt values at which the preamble switches to SSD and then to data
    localparam logic [3:0] PRE_SSD  = 4'(N_SYNC);
    localparam logic [3:0] PRE_LAST = 4'(N_SYNC + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_DATA     = 3'd2,
        ST_ESD      = 3'd3,
        ST_ESD_STAT = 3'd4,
        ST_CMD      = 3'd5
    } state_t;

    // Standard 4B/5B data code group
    function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
        logic [4:0] code;
        case (nib)
            4'h0:    code = 5'b11110;
            4'h1:    code = 5'b01001;
            4'h2:    code = 5'b10100;
            4'h3:    code = 5'b10101;
            4'h4:    code = 5'b01010;
            4'h5:    code = 5'b01011;
            4'h6:    code = 5'b01110;
            4'h7:    code = 5'b01111;
            4'h8:    code = 5'b10010;
            4'h9:    code = 5'b10011;
            4'hA:    code = 5'b10110;
            4'hB:    code = 5'b10111;
            4'hC:    code = 5'b11010;
            4'hD:    code = 5'b11011;
            4'hE:    code = 5'b11100;
            4'hF:    code = 5'b11101;
            default: code = SYM_SILENCE;
        endcase
        return code;
    endfunction

    // Line symbol for a non-NONE command
    function automatic logic [4:0] cmd_sym(input logic [1:0] cmd);
        logic [4:0] code;
        case (cmd)
            CMD_COMMIT: code = SYM_SYNC;
            CMD_BEACON: code = SYM_BEACON;
            default:    code = SYM_HB;
        endcase
        return code;
    endfunction

    state_t     state_r, state_s;
    logic [3:0] precnt_r, precnt_s;
    logic       err_seen_r, err_seen_s;
    logic [4:0] sym_r, sym_s;
    logic       trans_r, trans_s;

    // Next state, preamble counter, error flag and symbol; only a strobe moves anything
    always_comb begin
        state_s    = state_r;
        precnt_s   = precnt_r;
        err_seen_s = err_seen_r;
        sym_s      = sym_r;
        if (bus.tx_std) begin
            if (bus.link_control) begin
                state_s = ST_IDLE;
                sym_s   = SYM_SILENCE;
            end else begin
                case (state_r)
                    ST_IDLE, ST_CMD: begin
                        if (bus.TX_EN) begin
                            // frame start wins over any pending command
                            sym_s      = SYM_SYNC;
                            precnt_s   = 4'd1;
                            err_seen_s = 1'b0;
                            state_s    = ST_PRE;
                        end else if (bus.tx_cmd != CMD_NONE) begin
                            sym_s   = cmd_sym(bus.tx_cmd);
                            state_s = ST_CMD;
                        end else begin
                            sym_s   = SYM_SILENCE;
                            state_s = ST_IDLE;
                        end
                    end
                    ST_PRE: begin
                        if (!bus.TX_EN) begin
                            sym_s   = SYM_ESD;
                            state_s = ST_ESD;
                        end else begin
                            // TXD is deliberately ignored: preamble nibbles are replaced
                            if (precnt_r < PRE_SSD) begin
                                sym_s = SYM_SYNC;
                            end else begin
                                sym_s = SYM_SSD;
                            end
                            if (precnt_r >= PRE_LAST) begin
                                state_s = ST_DATA;
                            end else begin
                                state_s = ST_PRE;
                            end
                            precnt_s = (precnt_r == 4'hF) ? precnt_r : precnt_r + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (!bus.TX_EN) begin
                            sym_s   = SYM_ESD;
                            state_s = ST_ESD;
                        end else if (bus.TX_ER) begin
                            sym_s      = SYM_ERR;
                            err_seen_s = 1'b1;
                        end else begin
                            sym_s = enc_4b5b(bus.TXD);
                        end
                    end
                    ST_ESD: begin
                        sym_s   = err_seen_r ? SYM_ESDERR : SYM_ESDOK;
                        state_s = ST_ESD_STAT;
                    end
                    ST_ESD_STAT: begin
                        sym_s   = SYM_SILENCE;
                        state_s = ST_IDLE;
                    end
                    default: begin
                        sym_s   = SYM_SILENCE;
                        state_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
        trans_s = (state_s != ST_IDLE);
    end

    // State and registered outputs; reset drops any frame in flight at once
    always_ff @(posedge clk or posedge pcs_reset) begin
        if (pcs_reset) begin
            state_r    <= ST_IDLE;
            precnt_r   <= 4'd0;
            err_seen_r <= 1'b0;
            sym_r      <= SYM_SILENCE;
            trans_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            precnt_r   <= precnt_s;
            err_seen_r <= err_seen_s;
            sym_r      <= sym_s;
            trans_r    <= trans_s;
        end
    end

    assign bus.tx_sym       = sym_r;
    assign bus.transmitting = trans_r;
    assign bus.tx_state     = state_r;
endmodule
